lcd_digit_roller: RTL and testbench
===================================

# lcd_digit_roller

Multi-digit random-number display engine between `uart_rx` and the `st7735` driver. Each received UART byte triggers a roll, which assigns NUM_DIGITS glyph slots new pseudo-random values 0–9 from an internal 16-bit LFSR. The LFSR is seeded from a free-running counter on the first trigger after reset. The block computes the glyph-BRAM read address from the driver's pixel coordinates and converts the BRAM intensity into RGB565 grey.

## Interface
- NUM_DIGITS, 4: glyph slots shown left to right; 1..8.
- GW, 5: glyph width in 8×8-pixel cells; NUM_DIGITS·GW ≤ 20.
- GH, 10: glyph height in cells; ≤ 16.
- PIX_W, 4: BRAM intensity width; 1..5.
- AW, 10: BRAM address width; must satisfy 2^AW ≥ 10·GW·GH.

- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- rx_ready  in  1  one-cycle strobe, UART byte valid.
- rx_data  in  8  received byte.
- x  in  8  driver pixel column.
- y  in  7  driver pixel row.
- next_pixel  in  1  driver strobe requesting the next colour.
- color  out  16  RGB565 pixel to driver.
- mem_addr  out  AW  glyph BRAM read address (combinational).
- mem_dout  in  PIX_W  BRAM read data; 1-cycle read latency.
- busy  out  1  high while a roll is in progress.
- done  out  1  one-cycle pulse when a roll completes.
- digits  out  4·NUM_DIGITS  current digit values; slot 0 is in bits [3:0].

## Operation
- Reset values: color=0, busy=0, done=0, every digit=0, lfsr=0x0001, seeded=0, seed counter=0, state=IDLE.
- Seed counter: 16-bit, increments every non-reset cycle, wraps at 0xFFFF→0.
- LFSR: Galois form. Step: `lfsr = (lfsr>>1) ^ (lfsr[0] ? 0xB400 : 0)`. The LFSR never holds zero.
- Digit map: `d = (r[7:0]·10) >> 8`, where r is the current LFSR value. The product is 12 bits, so the result is always in 0..9.
- FSM states: IDLE, ROLL.
  - IDLE, rx_ready=1 (byte accepted): if seeded=0, then `lfsr ← counter | 1` and seeded ← 1. Then i ← 0, busy ← 1, state ← ROLL.
  - ROLL, each cycle: digit[i] ← map(lfsr), then lfsr steps. If i = NUM_DIGITS−1: done ← 1 for one cycle, busy ← 0, state ← IDLE. Otherwise i ← i+1.
  - When seeding occurs, digit[0] is taken from the seed value itself.
- rx_ready in ROLL: the byte is dropped. Neither the state nor the LFSR changes.
- Address generation:
  - col = x[7:3], row = y[6:3].
  - slot = the largest s with s·GW ≤ col, found by a constant comparison chain (no divider).
  - `mem_addr = digit[slot]·GW·GH + row·GW + (col − slot·GW)`.
- Blank region: if col ≥ NUM_DIGITS·GW or row ≥ GH, mem_addr = 0 and blank = 1.
- Digit update during scan: a digit changed mid-frame takes effect at the next address evaluation. Tearing across one frame is accepted.
- Colour:
  - On next_pixel: color ← blank_q ? 0 : {R,G,B}.
  - R and B are mem_dout left-justified in 5 bits, zero-filled. G is mem_dout left-justified in 6 bits, zero-filled.
  - blank_q is the blank flag registered one cycle, aligned with mem_dout.
  - With PIX_W=4 and mem_dout=0xF, color=0xF79E.

## Timing
- rx_ready at edge k → busy=1 from k+1. A roll lasts exactly NUM_DIGITS cycles.
- done is high in the cycle after the last digit write. The block re-accepts a trigger in that same cycle.
- The final digit is visible on `digits` from the cycle done rises.
- Pixel path: x/y → mem_addr is combinational. mem_dout and blank_q arrive at +1 cycle. color updates only on next_pixel, using the data present at that edge.
- Reset mid-roll: reset dominates. Everything returns to reset values next cycle, including seeded=0, so the next trigger reseeds.

## Configuration
- LCD_ROLL_DIRECT_EN defined: an accepted byte in ASCII '0'..'9' (0x30–0x39) does not roll.
  - Instead, in a single cycle, digits shift toward higher slots: digit[s] ← digit[s−1], digit[0] ← rx_data−0x30.
  - done pulses next cycle and busy stays 0. The LFSR and seeded are untouched.
  - All other bytes roll as normal.
- Undefined: every byte, digits included, triggers a roll.

## Test plan
- Reset, then hold rx_ready low → color=0, digits=0, busy=0; seed counter reaches 0x00FE after 254 cycles.
- Trigger rx_ready when counter=0x00FE → seed 0x00FF, digit[0]=9. The next three digits match the reference LFSR model. busy is high for 4 cycles, then done pulses once.
- Pulse rx_ready twice during ROLL → the second pulse is ignored: roll length stays 4 cycles, LFSR sequence unchanged.
- With digits={3,1,4,1}, scan x=40 (col 5), y=8 (row 1) → mem_addr = 1·50 + 1·5 + 0 = 55. At x=160 → blank, color=0 on next_pixel.
- mem_dout=0xF then next_pixel → color=0xF79E. mem_dout=0x8 → color=0x8410.
- LCD_ROLL_DIRECT_EN: send '7', then '2' → digit[0]=2, digit[1]=7, busy never asserted. Send 'x' → a normal 4-cycle roll.

Source files
------------

// File: rtl/lcd_digit_roller_if.sv
// Bundle between the roller and its UART / LCD-driver / glyph-BRAM peers.
// slave: roller side; master: the surrounding system (or a bench).
interface lcd_digit_roller_if #(
  parameter int NUM_DIGITS = 4,
  parameter int PIX_W      = 4,
  parameter int AW         = 10
);
  logic                    rx_ready;
  logic [7:0]              rx_data;
  logic [7:0]              x;
  logic [6:0]              y;
  logic                    next_pixel;
  logic [15:0]             color;
  logic [AW-1:0]           mem_addr;
  logic [PIX_W-1:0]        mem_dout;
  logic                    busy;
  logic                    done;
  logic [4*NUM_DIGITS-1:0] digits;

  modport slave (
    input  rx_ready, rx_data, x, y, next_pixel, mem_dout,
    output color, mem_addr, busy, done, digits
  );

  modport master (
    output rx_ready, rx_data, x, y, next_pixel, mem_dout,
    input  color, mem_addr, busy, done, digits
  );
endinterface

// File: rtl/lcd_digit_roller.sv
// Random multi-digit display engine: UART byte rolls digits from an LFSR,
// maps driver x/y to a glyph-BRAM address and BRAM intensity to RGB565.
// Ports: clk, reset (sync, active-low), bus (slave modport: rx_ready,
// rx_data, x, y, next_pixel, mem_dout in; color, mem_addr, busy, done,
// digits out). Option macro LCD_ROLL_DIRECT_EN: ASCII '0'..'9' bytes
// shift straight into the digits instead of rolling.
module lcd_digit_roller #(
  parameter int NUM_DIGITS = 4,
  parameter int GW         = 5,
  parameter int GH         = 10,
  parameter int PIX_W      = 4,
  parameter int AW         = 10
) (
  input  logic           clk,
  input  logic           reset,
  lcd_digit_roller_if.slave bus
);

  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, ROLL} state_t;

  function automatic logic [3:0] dmap(input logic [7:0] r);
    dmap = 4'((12'(r) * 12'd10) >> 8);
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] r);
    lstep = (r >> 1) ^ (r[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t                          state_q, state_d;
  logic [15:0]                     lfsr_q, lfsr_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic                            seeded_q, seeded_d;
  logic [SW-1:0]                   i_q, i_d;
  logic [NUM_DIGITS-1:0][3:0]      dig_q, dig_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            blank_q, blank_d;
  logic [15:0]                     color_q, color_d;

  logic                            direct_hit;
  logic [3:0]                      direct_val;
  logic                            unused_bits;

  assign unused_bits = ^{bus.x[2:0], bus.y[2:0], bus.rx_data};

`ifdef LCD_ROLL_DIRECT_EN
  assign direct_hit = (bus.rx_data >= 8'h30) &&
                      (bus.rx_data <= 8'h39);
`else
  assign direct_hit = 1'b0;
`endif
  assign direct_val = 4'(bus.rx_data - 8'h30);

  // Control: trigger handling, roll sequencing, seeding.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q + 16'd1;
    seeded_d = seeded_q;
    i_d      = i_q;
    dig_d    = dig_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rx_ready) begin
          if (direct_hit) begin
            for (int s = NUM_DIGITS - 1; s > 0; s--)
              dig_d[s] = dig_q[s-1];
            dig_d[0] = direct_val;
            done_d   = 1'b1;
          end else begin
            // First roll after reset seeds from the free-running count;
            // forcing bit 0 keeps the LFSR out of the all-zero lock-up.
            if (!seeded_q) begin
              lfsr_d   = cnt_q | 16'h0001;
              seeded_d = 1'b1;
            end
            i_d     = '0;
            busy_d  = 1'b1;
            state_d = ROLL;
          end
        end
      end
      ROLL: begin
        dig_d[i_q] = dmap(lfsr_q[7:0]);
        lfsr_d     = lstep(lfsr_q);
        if (i_q == LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          i_d = i_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel address: slot found by a constant compare chain, no divider.
  int unsigned col_i, row_i, base_i, addr_i;
  logic [SW-1:0] slot;
  logic          blank;

  always_comb begin
    col_i  = 32'(bus.x[7:3]);
    row_i  = 32'(bus.y[6:3]);
    slot   = '0;
    base_i = 0;
    for (int s = 1; s < NUM_DIGITS; s++) begin
      if (col_i >= 32'(s * GW)) begin
        slot   = SW'(s);
        base_i = 32'(s * GW);
      end
    end
    blank  = (col_i >= 32'(NUM_DIGITS * GW)) || (row_i >= 32'(GH));
    addr_i = 32'(dig_q[slot]) * 32'(GW * GH) +
             row_i * 32'(GW) + (col_i - base_i);
    if (blank) addr_i = 0;
    bus.mem_addr = AW'(addr_i);
    blank_d = blank;
  end

  // Colour: intensity left-justified into grey RGB565.
  logic [4:0] rb5;
  logic [5:0] g6;

  always_comb begin
    rb5     = 5'(bus.mem_dout) << (5 - PIX_W);
    g6      = 6'(bus.mem_dout) << (6 - PIX_W);
    color_d = color_q;
    if (bus.next_pixel)
      color_d = blank_q ? 16'h0000 : {rb5, g6, rb5};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      lfsr_q   <= 16'h0001;
      cnt_q    <= 16'h0000;
      seeded_q <= 1'b0;
      i_q      <= '0;
      dig_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      blank_q  <= 1'b0;
      color_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      seeded_q <= seeded_d;
      i_q      <= i_d;
      dig_q    <= dig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      blank_q  <= blank_d;
      color_q  <= color_d;
    end
  end

  assign bus.color  = color_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.digits = dig_q;

endmodule

// File: tb/tb_lcd_digit_roller.sv
// Directed bench for lcd_digit_roller: roll sequences, ignored triggers,
// address mapping, colour conversion, mid-roll reset.
module tb_lcd_digit_roller;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  lcd_digit_roller_if #(.NUM_DIGITS(4), .PIX_W(4), .AW(10)) bus ();

  lcd_digit_roller #(
    .NUM_DIGITS(4), .GW(5), .GH(10), .PIX_W(4), .AW(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.rx_ready   = 1'b0;
    bus.rx_data    = 8'h41;
    bus.x          = 8'd0;
    bus.y          = 7'd0;
    bus.next_pixel = 1'b0;
    bus.mem_dout   = 4'h0;
    repeat (3) tick();
    chk("rst_color",  32'(bus.color),  32'h0);
    chk("rst_digits", 32'(bus.digits), 32'h0);
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_done",   32'(bus.done),   32'h0);
    reset = 1'b1;

    // 254 free-running cycles: counter = 0x00FE, seed becomes 0x00FF.
    repeat (254) tick();
    chk("idle_busy", 32'(bus.busy), 32'h0);
    pulse_rx(8'h41);
    chk("r1_busy0", 32'(bus.busy),   32'h1);
    chk("r1_dig0",  32'(bus.digits), 32'h0);
    tick();
    chk("r1_d0",    32'(bus.digits), 32'h0009);
    chk("r1_busy1", 32'(bus.busy),   32'h1);
    tick();
    chk("r1_d1",    32'(bus.digits), 32'h0049);
    tick();
    chk("r1_d2",    32'(bus.digits), 32'h0249);
    chk("r1_busy3", 32'(bus.busy),   32'h1);
    chk("r1_done3", 32'(bus.done),   32'h0);
    tick();
    chk("r1_d3",    32'(bus.digits), 32'h1249);
    chk("r1_busyE", 32'(bus.busy),   32'h0);
    chk("r1_done",  32'(bus.done),   32'h1);
    tick();
    chk("r1_doneX", 32'(bus.done),   32'h0);

    // Second roll with two extra triggers that must be dropped.
    pulse_rx(8'h42);
    chk("r2_busy", 32'(bus.busy), 32'h1);
    tick();
    pulse_rx(8'h43);
    chk("r2_ign1", 32'(bus.digits), 32'h1275);
    chk("r2_busy2", 32'(bus.busy), 32'h1);
    pulse_rx(8'h44);
    chk("r2_ign2", 32'(bus.digits), 32'h1375);
    tick();
    chk("r2_d3",   32'(bus.digits), 32'h6375);
    chk("r2_done", 32'(bus.done),   32'h1);
    chk("r2_busyE", 32'(bus.busy),  32'h0);

    // Trigger in the done cycle is accepted.
    pulse_rx(8'h45);
    chk("r3_busy", 32'(bus.busy), 32'h1);
    chk("r3_done", 32'(bus.done), 32'h0);
    repeat (4) tick();
    chk("r3_dig",  32'(bus.digits), 32'h1248);
    chk("r3_doneE", 32'(bus.done),  32'h1);
    tick();

    // Address map with digits {1,2,4,8} (slot 0 = 8).
    bus.x = 8'd40;  bus.y = 7'd8;  #1;
    chk("addr_c5r1",  32'(bus.mem_addr), 32'd205);
    bus.x = 8'd0;   bus.y = 7'd0;  #1;
    chk("addr_0",     32'(bus.mem_addr), 32'd400);
    bus.x = 8'd152; bus.y = 7'd72; #1;
    chk("addr_c19r9", 32'(bus.mem_addr), 32'd99);
    bus.x = 8'd79;  bus.y = 7'd15; #1;
    chk("addr_c9r1",  32'(bus.mem_addr), 32'd209);
    bus.x = 8'd80;  bus.y = 7'd127; #1;
    chk("addr_rowbl", 32'(bus.mem_addr), 32'd0);
    bus.x = 8'd160; bus.y = 7'd0;  #1;
    chk("addr_colbl", 32'(bus.mem_addr), 32'd0);

    // Colour path.
    bus.x = 8'd40; bus.y = 7'd8; bus.mem_dout = 4'hF;
    tick();
    bus.next_pixel = 1'b1;
    tick();
    bus.next_pixel = 1'b0;
    chk("col_F", 32'(bus.color), 32'hF79E);
    bus.mem_dout = 4'h8;
    tick();
    chk("col_hold", 32'(bus.color), 32'hF79E);
    bus.next_pixel = 1'b1;
    tick();
    bus.next_pixel = 1'b0;
    chk("col_8", 32'(bus.color), 32'h8410);
    bus.x = 8'd160; bus.mem_dout = 4'hF;
    tick();
    bus.next_pixel = 1'b1;
    tick();
    bus.next_pixel = 1'b0;
    chk("col_blank", 32'(bus.color), 32'h0);

    // Reset mid-roll, then reseed from counter 0x0040 -> seed 0x0041.
    pulse_rx(8'h46);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mr_digits", 32'(bus.digits), 32'h0);
    chk("mr_busy",   32'(bus.busy),   32'h0);
    chk("mr_color",  32'(bus.color),  32'h0);
    repeat (64) tick();
    pulse_rx(8'h47);
    tick();
    chk("mr_reseed", 32'(bus.digits), 32'h0002);
    repeat (3) tick();
    chk("mr_dig",  32'(bus.digits), 32'h0012);
    chk("mr_done", 32'(bus.done),   32'h1);
    tick();

`ifdef LCD_ROLL_DIRECT_EN
    pulse_rx(8'h37);
    chk("dir7_busy", 32'(bus.busy),        32'h0);
    chk("dir7_done", 32'(bus.done),        32'h1);
    chk("dir7_dig",  32'(bus.digits[3:0]), 32'h7);
    pulse_rx(8'h32);
    chk("dir2_dig",  32'(bus.digits[7:0]), 32'h72);
    chk("dir2_busy", 32'(bus.busy),        32'h0);
    tick();
    pulse_rx(8'h78);
    chk("dirx_busy", 32'(bus.busy), 32'h1);
    repeat (3) tick();
    chk("dirx_busy3", 32'(bus.busy), 32'h1);
    tick();
    chk("dirx_done", 32'(bus.done), 32'h1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
